// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle for the multi-cycle RV32I control unit.
// master = controller side, slave = datapath/IR side.
interface multicycle_control_unit_if #(
   parameter int ALUCTRL_W = 4,
   parameter int IMMSRC_W  = 3,
   parameter int STATE_W   = 4
);
   logic [6:0]           Opcode;
   logic [2:0]           func3;
   logic                 func7b5;
   logic                 zero;
   logic                 neg;
   logic                 carry;
   logic                 ovf;
   logic                 mem_ready;
   logic                 PCWrite;
   logic                 AdrSrc;
   logic                 MemRead;
   logic                 MemWrite;
   logic                 IRWrite;
   logic [1:0]           ResultSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [IMMSRC_W-1:0]  ImmSrc;
   logic                 RegWrite;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic [STATE_W-1:0]   state_o;
   logic                 illegal;

   modport master (
      input  Opcode, func3, func7b5, zero, neg, carry, ovf, mem_ready,
      output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, state_o, illegal
   );

   modport slave (
      output Opcode, func3, func7b5, zero, neg, carry, ovf, mem_ready,
      input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, state_o, illegal
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller FSM with memory-ready stalls.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal) instead of executing as NOP.
module multicycle_control_unit #(
   parameter int ALUCTRL_W = 4,
   parameter int IMMSRC_W  = 3,
   parameter int STATE_W   = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);
   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(4'd0),
      S_DECODE   = STATE_W'(4'd1),
      S_MEMADR   = STATE_W'(4'd2),
      S_MEMREAD  = STATE_W'(4'd3),
      S_MEMWB    = STATE_W'(4'd4),
      S_MEMWRITE = STATE_W'(4'd5),
      S_EXECR    = STATE_W'(4'd6),
      S_EXECI    = STATE_W'(4'd7),
      S_ALUWB    = STATE_W'(4'd8),
      S_BRANCH   = STATE_W'(4'd9),
      S_JAL      = STATE_W'(4'd10),
      S_JALR     = STATE_W'(4'd11),
      S_LUI      = STATE_W'(4'd12),
      S_TRAP     = STATE_W'(4'd13)
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(3'd0);
   localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(3'd1);
   localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(3'd2);
   localparam logic [IMMSRC_W-1:0] IMM_J = IMMSRC_W'(3'd3);
   localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(3'd4);

   localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(4'd0);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(4'd1);
   localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(4'd2);
   localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(4'd3);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4'd4);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(4'd5);
   localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(4'd6);
   localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(4'd7);
   localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(4'd8);
   localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(4'd9);

   // SUB only for R-type (Opcode[5]=1); ADDI with IR[30] set is still ADD.
   function automatic logic [ALUCTRL_W-1:0] alu_decode(input logic [2:0] f3,
                                                       input logic f7b5,
                                                       input logic op5);
      logic [ALUCTRL_W-1:0] ctl;
      case (f3)
         3'b000:  if (f7b5 && op5) ctl = ALU_SUB; else ctl = ALU_ADD;
         3'b001:  ctl = ALU_SLL;
         3'b010:  ctl = ALU_SLT;
         3'b011:  ctl = ALU_SLTU;
         3'b100:  ctl = ALU_XOR;
         3'b101:  if (f7b5) ctl = ALU_SRA; else ctl = ALU_SRL;
         3'b110:  ctl = ALU_OR;
         3'b111:  ctl = ALU_AND;
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

   // Flags come from rs1-rs2; carry=1 means no borrow, i.e. rs1 >= rs2 unsigned.
   function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                         input logic n, input logic c, input logic v);
      logic t;
      case (f3)
         3'b000:  t = z;
         3'b001:  t = ~z;
         3'b100:  t = n ^ v;
         3'b101:  t = ~(n ^ v);
         3'b110:  t = ~c;
         3'b111:  t = c;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   state_t state_q, state_d;
`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   logic                 pc_write_s, adr_src_s, mem_read_s, mem_write_s, ir_write_s, reg_write_s;
   logic [1:0]           result_src_s, alu_src_a_s, alu_src_b_s;
   logic [IMMSRC_W-1:0]  imm_src_s;
   logic [ALUCTRL_W-1:0] alu_ctrl_s;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
`else
                  state_d   = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR:   if (bus.Opcode[5]) state_d = S_MEMWRITE; else state_d = S_MEMREAD;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB; else state_d = S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH; else state_d = S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_ALUWB;
         S_LUI:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`else
         S_TRAP:     state_d = S_FETCH;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // State register; async reset lands in FETCH so all write strobes drop at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   // Sticky illegal-opcode flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end
   assign bus.illegal = illegal_q;
`else
   assign bus.illegal = 1'b0;
`endif

   // Control decode from state; only the fetch/branch PC strobes look at live inputs.
   always_comb begin
      pc_write_s   = 1'b0;
      adr_src_s    = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      result_src_s = 2'd0;
      alu_src_a_s  = 2'd0;
      alu_src_b_s  = 2'd0;
      imm_src_s    = IMM_I;
      alu_ctrl_s   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mem_read_s   = 1'b1;
            alu_src_b_s  = 2'd2;
            result_src_s = 2'd2;
            pc_write_s   = bus.mem_ready;
            ir_write_s   = bus.mem_ready;
         end
         S_DECODE: begin
            alu_src_a_s = 2'd1;
            alu_src_b_s = 2'd1;
            if (bus.Opcode == OP_JAL) imm_src_s = IMM_J; else imm_src_s = IMM_B;
         end
         S_MEMADR: begin
            alu_src_a_s = 2'd2;
            alu_src_b_s = 2'd1;
            if (bus.Opcode[5]) imm_src_s = IMM_S; else imm_src_s = IMM_I;
         end
         S_MEMREAD: begin
            mem_read_s = 1'b1;
            adr_src_s  = 1'b1;
         end
         S_MEMWB: begin
            result_src_s = 2'd1;
            reg_write_s  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_write_s = 1'b1;
            adr_src_s   = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_s = 2'd2;
            alu_ctrl_s  = alu_decode(bus.func3, bus.func7b5, bus.Opcode[5]);
         end
         S_EXECI: begin
            alu_src_a_s = 2'd2;
            alu_src_b_s = 2'd1;
            alu_ctrl_s  = alu_decode(bus.func3, bus.func7b5, bus.Opcode[5]);
         end
         S_ALUWB:    reg_write_s = 1'b1;
         S_BRANCH: begin
            alu_src_a_s = 2'd2;
            alu_ctrl_s  = ALU_SUB;
            pc_write_s  = branch_taken(bus.func3, bus.zero, bus.neg, bus.carry, bus.ovf);
         end
         S_JAL: begin
            alu_src_a_s = 2'd1;
            alu_src_b_s = 2'd2;
            pc_write_s  = 1'b1;
         end
         S_JALR: begin
            alu_src_a_s  = 2'd2;
            alu_src_b_s  = 2'd1;
            result_src_s = 2'd2;
            pc_write_s   = 1'b1;
         end
         S_LUI: begin
            imm_src_s    = IMM_U;
            result_src_s = 2'd3;
            reg_write_s  = 1'b1;
         end
         default: pc_write_s = 1'b0;
      endcase
   end

   assign bus.PCWrite    = pc_write_s;
   assign bus.AdrSrc     = adr_src_s;
   assign bus.MemRead    = mem_read_s;
   assign bus.MemWrite   = mem_write_s;
   assign bus.IRWrite    = ir_write_s;
   assign bus.ResultSrc  = result_src_s;
   assign bus.ALUSrcA    = alu_src_a_s;
   assign bus.ALUSrcB    = alu_src_b_s;
   assign bus.ImmSrc     = imm_src_s;
   assign bus.RegWrite   = reg_write_s;
   assign bus.ALUControl = alu_ctrl_s;
   assign bus.state_o    = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle expected control words
// are queued as stimulus is applied and compared at the falling edge.
module tb_multicycle_control_unit;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic [1:0] rsrc;
      logic [1:0] asa;
      logic [1:0] asb;
      logic [2:0] imm;
      logic       rw;
      logic [3:0] aluc;
      logic       ill;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   multicycle_control_unit_if bus ();
   multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Expected control word for a state, straight from the state table.
   function automatic obs_t spec_out(input logic [3:0] st, input logic mr, input logic taken,
                                     input logic is_jal, input logic is_store,
                                     input logic [3:0] aluc_x);
      obs_t o = '0;
      o.st = st;
      case (st)
         4'd0:  begin o.mrd = 1'b1; o.asb = 2'd2; o.rsrc = 2'd2; o.pcw = mr; o.irw = mr; end
         4'd1:  begin o.asa = 2'd1; o.asb = 2'd1; o.imm = is_jal ? 3'd3 : 3'd2; end
         4'd2:  begin o.asa = 2'd2; o.asb = 2'd1; o.imm = is_store ? 3'd1 : 3'd0; end
         4'd3:  begin o.mrd = 1'b1; o.adr = 1'b1; end
         4'd4:  begin o.rsrc = 2'd1; o.rw = 1'b1; end
         4'd5:  begin o.mwr = 1'b1; o.adr = 1'b1; end
         4'd6:  begin o.asa = 2'd2; o.aluc = aluc_x; end
         4'd7:  begin o.asa = 2'd2; o.asb = 2'd1; o.aluc = aluc_x; end
         4'd8:  o.rw = 1'b1;
         4'd9:  begin o.asa = 2'd2; o.aluc = 4'd1; o.pcw = taken; end
         4'd10: begin o.asa = 2'd1; o.asb = 2'd2; o.pcw = 1'b1; end
         4'd11: begin o.asa = 2'd2; o.asb = 2'd1; o.rsrc = 2'd2; o.pcw = 1'b1; end
         4'd12: begin o.imm = 3'd4; o.rsrc = 2'd3; o.rw = 1'b1; end
         4'd13: o.ill = 1'b1;
         default: o.st = st;
      endcase
      return o;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.st   = bus.state_o;
      o.pcw  = bus.PCWrite;
      o.adr  = bus.AdrSrc;
      o.mrd  = bus.MemRead;
      o.mwr  = bus.MemWrite;
      o.irw  = bus.IRWrite;
      o.rsrc = bus.ResultSrc;
      o.asa  = bus.ALUSrcA;
      o.asb  = bus.ALUSrcB;
      o.imm  = bus.ImmSrc;
      o.rw   = bus.RegWrite;
      o.aluc = bus.ALUControl;
      o.ill  = bus.illegal;
      return o;
   endfunction

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      bus.Opcode  = op;
      bus.func3   = f3;
      bus.func7b5 = f7;
      bus.zero    = 1'b0;
      bus.neg     = 1'b0;
      bus.carry   = 1'b0;
      bus.ovf     = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, want;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(spec_out(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
         rst_n = 1'b1;
      end
   endtask

   task automatic test_load_stall();
      logic [3:0] st [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      logic       mr [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      obs_t got, want;
      set_instr(7'b0000011, 3'b010, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.mem_ready = mr[i];
         exp_q.push_back(spec_out(st[i], mr[i], 1'b0, 1'b0, 1'b0, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL load_stall[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      logic       mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      obs_t got, want;
      set_instr(7'b0100011, 3'b010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready = mr[i];
         exp_q.push_back(spec_out(st[i], mr[i], 1'b0, 1'b0, 1'b1, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL store[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_decode();
      logic [6:0] ops  [6] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
      logic [2:0] f3s  [6] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b101, 3'b010};
      logic       f7s  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] alus [6] = '{4'd1, 4'd0, 4'd0, 4'd9, 4'd8, 4'd5};
      logic [3:0] st [5];
      logic       mr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      obs_t got, want;
      for (int j = 0; j < 6; j++) begin
         set_instr(ops[j], f3s[j], f7s[j]);
         st = '{4'd0, 4'd1, (ops[j][4] && !ops[j][5]) ? 4'd7 : 4'd6, 4'd8, 4'd0};
         for (int i = 0; i < 5; i++) begin
            bus.mem_ready = mr[i];
            exp_q.push_back(spec_out(st[i], mr[i], 1'b0, 1'b0, 1'b0, alus[j]));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL alu_decode[%0d.%0d]: got %h expected %h", j, i, got, want);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3s [8] = '{3'b110, 3'b110, 3'b100, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010};
      logic [3:0] flg [8] = '{4'b0000, 4'b0010, 4'b0101, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b1000};
      logic       tkn [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0] st  [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
      logic       mr  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      obs_t got, want;
      for (int j = 0; j < 8; j++) begin
         set_instr(7'b1100011, f3s[j], 1'b0);
         {bus.zero, bus.neg, bus.carry, bus.ovf} = flg[j];
         for (int i = 0; i < 4; i++) begin
            bus.mem_ready = mr[i];
            exp_q.push_back(spec_out(st[i], mr[i], tkn[j], 1'b0, 1'b0, 4'd0));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL branch[%0d.%0d]: got %h expected %h", j, i, got, want);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_jumps_lui();
      logic [6:0] ops [3] = '{7'b1101111, 7'b1100111, 7'b0110111};
      logic [3:0] mid [3] = '{4'd10, 4'd11, 4'd12};
      int         len [3] = '{5, 5, 4};
      logic [3:0] st [5];
      obs_t got, want;
      for (int j = 0; j < 3; j++) begin
         set_instr(ops[j], 3'b000, 1'b0);
         if (j == 2) st = '{4'd0, 4'd1, 4'd12, 4'd0, 4'd0};
         else        st = '{4'd0, 4'd1, mid[j], 4'd8, 4'd0};
         for (int i = 0; i < len[j]; i++) begin
            bus.mem_ready = (i == 0);
            exp_q.push_back(spec_out(st[i], (i == 0), 1'b0, (j == 0), 1'b0, 4'd0));
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL jump_lui[%0d.%0d]: got %h expected %h", j, i, got, want);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      int         n = 22;
      logic [3:0] tail = 4'd13;
`else
      int         n = 3;
      logic [3:0] tail = 4'd0;
`endif
      logic [3:0] st;
      obs_t got, want;
      set_instr(7'b0000000, 3'b000, 1'b0);
      for (int i = 0; i < n; i++) begin
         bus.mem_ready = (i == 0);
         st = (i == 0) ? 4'd0 : ((i == 1) ? 4'd1 : tail);
         exp_q.push_back(spec_out(st, (i == 0), 1'b0, 1'b0, 1'b0, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL illegal[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_write();
      logic [3:0] st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
      obs_t got, want;
      // A sticky TRAP from the previous scenario only clears through reset.
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_instr(7'b0100011, 3'b010, 1'b0);
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready = (i == 0);
         exp_q.push_back(spec_out(st[i], (i == 0), 1'b0, 1'b0, 1'b1, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL rst_mid[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      // Still in MEMWRITE here; reset must clear state and MemWrite without a clock edge.
      bus.mem_ready = 1'b0;
      #1 rst_n = 1'b0;
      exp_q.push_back(spec_out(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      #1;
      got  = observe();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL rst_async: got %h expected %h", got, want);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.mem_ready = (i == 0);
         exp_q.push_back(spec_out((i == 0) ? 4'd0 : 4'd1, (i == 0), 1'b0, 1'b0, 1'b1, 4'd0));
         @(negedge clk);
         got  = observe();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL rst_restart[%0d]: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      set_instr(7'b0000000, 3'b000, 1'b0);
      test_reset();
      test_load_stall();
      test_store();
      test_alu_decode();
      test_branch();
      test_jumps_lui();
      test_illegal();
      test_reset_mid_write();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
